// File: rtl/fix15_mul_arbiter_if.sv
// Handshake bundle between the boid-update requesters and the shared fix15 multiplier.
// Requesters use the master view; the arbiter uses the slave view.
interface fix15_mul_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;
    logic                resp_valid;
    logic [ID_W-1:0]     resp_id;
    logic [31:0]         resp_q;
    logic                resp_ready;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_q
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_q
    );
endinterface

// File: rtl/fix15_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined Q16.15 multiplier among N_REQ requesters.
// Results return in issue order, tagged with the requester ID; a stalled output freezes the whole pipe.
module fix15_mul_arbiter #(
    parameter int N_REQ = 4,
    parameter int PIPE  = 2,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    fix15_mul_arbiter_if.slave bus
);
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  idx;
    logic [ID_W-1:0]  win_id;
    logic             win_found;
    logic [N_REQ-1:0] grant;
    logic             stall;
    logic             issue;

    logic [31:0]      a_sel;
    logic [31:0]      b_sel;
    logic [63:0]      a_ext;
    logic [63:0]      b_ext;
    logic [31:0]      mul_q;

    logic             v_pipe  [PIPE];
    logic [ID_W-1:0]  id_pipe [PIPE];
    logic [31:0]      q_pipe  [PIPE];

    logic             resp_valid_r;
    logic [ID_W-1:0]  resp_id_r;
    logic [31:0]      resp_q_r;

    assign stall = resp_valid_r && !bus.resp_ready;

    // Search p, p+1, ... wrapping; first valid requester wins.
    always_comb begin
        idx       = '0;
        win_id    = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ID_W'((32'(ptr) + i) % N_REQ);
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (win_found && !stall && reset_n) begin
            grant[win_id] = 1'b1;
        end
    end

    assign issue         = |grant;
    assign bus.req_ready = grant;

    // Product is formed at issue; the trailing stages give the tools room to retime into DSP registers.
    assign a_sel = bus.req_a[32*win_id +: 32];
    assign b_sel = bus.req_b[32*win_id +: 32];
    assign a_ext = {{32{a_sel[31]}}, a_sel};
    assign b_ext = {{32{b_sel[31]}}, b_sel};
    assign mul_q = 32'((a_ext * b_ext) >> 15);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s < PIPE; s++) begin
                v_pipe[s]  <= 1'b0;
                id_pipe[s] <= '0;
                q_pipe[s]  <= '0;
            end
            resp_valid_r <= 1'b0;
            resp_id_r    <= '0;
            resp_q_r     <= '0;
            ptr          <= '0;
        end else if (!stall) begin
            v_pipe[0]  <= issue;
            id_pipe[0] <= win_id;
            q_pipe[0]  <= mul_q;
            for (int unsigned s = 1; s < PIPE; s++) begin
                v_pipe[s]  <= v_pipe[s-1];
                id_pipe[s] <= id_pipe[s-1];
                q_pipe[s]  <= q_pipe[s-1];
            end
            resp_valid_r <= v_pipe[PIPE-1];
            resp_id_r    <= id_pipe[PIPE-1];
            resp_q_r     <= q_pipe[PIPE-1];
            if (issue) begin
                ptr <= ID_W'((32'(win_id) + 32'd1) % N_REQ);
            end
        end
    end

    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_id    = resp_id_r;
    assign bus.resp_q     = resp_q_r;
endmodule
